maxpool_sched: RTL and testbench

- Sequencer for the 2x2/stride-2 max-pool unit of the VGG16 accelerator.
- Walks a channel-major feature map in on-chip RAM and issues the four read addresses of each window.
- Drives the pool unit's stage-1 and stage-2 enables, then writes each pooled result to the output buffer.
- One window per cycle in steady state; a single downstream ready signal can stall the whole pipeline.

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_addr_gen.sv | 128 ++++++++++++
 rtl/maxpool_sched.sv | 190 +++++++++++++++++++
 tb/tb_maxpool_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2/stride-2 max-pool sequencer.
//   - default parameter widths for the sequencer and its address generator
//   - POOL_LAT: cycles from window issue to pooled-result write
//   - sequencer FSM state encoding
package pool_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 20;
   localparam int unsigned DEF_DIM_WIDTH  = 8;
   localparam int unsigned DEF_CH_WIDTH   = 10;

   // RAM read (1) + pool stage 1 (1) + pool stage 2 (1)
   localparam int unsigned POOL_LAT = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FIN   = 3'd4
   } pool_state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// Window address generator for the max-pool sequencer.
// Walks output column (fastest), output row, then channel, and produces the
// four input-map addresses of the current 2x2 window using running bases
// (no per-window multiply).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   init              clear counters/bases at job start
//   advance           current window issued this cycle; step to the next
//   width             input map width W
//   out_w, out_h      output map width/height (W>>1, H>>1)
//   channels          channel count C
//   plane             H*W, channel stride in the input map
//   addr_{a,b,c,d}_c  TL/TR/BL/BR addresses, zero unless advance is high
//   last_c            current window is the final one of the job
module pool_addr_gen
   import pool_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH,
   parameter int unsigned CH_WIDTH   = DEF_CH_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init,
   input  logic                  advance,
   input  logic [DIM_WIDTH-1:0]  width,
   input  logic [DIM_WIDTH-1:0]  out_w,
   input  logic [DIM_WIDTH-1:0]  out_h,
   input  logic [CH_WIDTH-1:0]   channels,
   input  logic [ADDR_WIDTH-1:0] plane,
   output logic [ADDR_WIDTH-1:0] addr_a_c,
   output logic [ADDR_WIDTH-1:0] addr_b_c,
   output logic [ADDR_WIDTH-1:0] addr_c_c,
   output logic [ADDR_WIDTH-1:0] addr_d_c,
   output logic                  last_c
);

   logic [DIM_WIDTH-1:0]  ocol_q, ocol_d;
   logic [DIM_WIDTH-1:0]  orow_q, orow_d;
   logic [CH_WIDTH-1:0]   ch_q, ch_d;
   logic [ADDR_WIDTH-1:0] ch_base_q, ch_base_d;
   logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
   logic [ADDR_WIDTH-1:0] col_off_q, col_off_d;

   logic                  col_last_c;
   logic                  row_last_c;
   logic                  ch_last_c;
   logic [ADDR_WIDTH-1:0] width_ext_c;
   logic [ADDR_WIDTH-1:0] base_c;

   // Window position decode and address formation
   always_comb begin
      width_ext_c = ADDR_WIDTH'(width);
      col_last_c  = (ocol_q == out_w - DIM_WIDTH'(1));
      row_last_c  = (orow_q == out_h - DIM_WIDTH'(1));
      ch_last_c   = (ch_q == channels - CH_WIDTH'(1));
      last_c      = col_last_c & row_last_c & ch_last_c;
      base_c      = ch_base_q + row_base_q + col_off_q;

      // Addresses are only meaningful while a window is being issued
      addr_a_c = '0;
      addr_b_c = '0;
      addr_c_c = '0;
      addr_d_c = '0;
      if (advance) begin
         addr_a_c = base_c;
         addr_b_c = base_c + ADDR_WIDTH'(1);
         addr_c_c = base_c + width_ext_c;
         addr_d_c = base_c + width_ext_c + ADDR_WIDTH'(1);
      end
   end

   // Counter and base accumulator stepping
   always_comb begin
      ocol_d     = ocol_q;
      orow_d     = orow_q;
      ch_d       = ch_q;
      ch_base_d  = ch_base_q;
      row_base_d = row_base_q;
      col_off_d  = col_off_q;

      if (init) begin
         ocol_d     = '0;
         orow_d     = '0;
         ch_d       = '0;
         ch_base_d  = '0;
         row_base_d = '0;
         col_off_d  = '0;
      end else if (advance) begin
         if (!col_last_c) begin
            ocol_d    = ocol_q + DIM_WIDTH'(1);
            col_off_d = col_off_q + ADDR_WIDTH'(2);
         end else begin
            ocol_d    = '0;
            col_off_d = '0;
            if (!row_last_c) begin
               orow_d     = orow_q + DIM_WIDTH'(1);
               // two input rows per output row
               row_base_d = row_base_q + (width_ext_c << 1);
            end else begin
               orow_d     = '0;
               row_base_d = '0;
               ch_d       = ch_q + CH_WIDTH'(1);
               ch_base_d  = ch_base_q + plane;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ocol_q     <= '0;
         orow_q     <= '0;
         ch_q       <= '0;
         ch_base_q  <= '0;
         row_base_q <= '0;
         col_off_q  <= '0;
      end else begin
         ocol_q     <= ocol_d;
         orow_q     <= orow_d;
         ch_q       <= ch_d;
         ch_base_q  <= ch_base_d;
         row_base_q <= row_base_d;
         col_off_q  <= col_off_d;
      end
   end

endmodule

// File: rtl/maxpool_sched.sv
// Sequencer for the 2x2/stride-2 max-pool unit.
// Issues one window (four read addresses) per cycle, tracks the window through
// RAM read, pool stage 1 and pool stage 2 with a valid pipe, and writes each
// pooled result to consecutive output-buffer addresses. out_ready low freezes
// everything.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      job start pulse; latches cfg_* when idle
//   cfg_width/height/channels  input map W, H, C
//   busy, done                 job in progress / one-cycle end-of-job pulse
//   out_ready                  downstream accept; low stalls the pipeline
//   rd_en, rd_addr_a..d        input RAM read strobe and window addresses
//   pool_v0, pool_v1           pool unit stage-1 / stage-2 enables
//   wr_en, wr_addr             output buffer write strobe and address
module maxpool_sched
   import pool_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DIM_WIDTH  = DEF_DIM_WIDTH,
   parameter int unsigned CH_WIDTH   = DEF_CH_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_width,
   input  logic [DIM_WIDTH-1:0]  cfg_height,
   input  logic [CH_WIDTH-1:0]   cfg_channels,
   output logic                  busy,
   output logic                  done,
   input  logic                  out_ready,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr_a,
   output logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [ADDR_WIDTH-1:0] rd_addr_c,
   output logic [ADDR_WIDTH-1:0] rd_addr_d,
   output logic                  pool_v0,
   output logic                  pool_v1,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr
);

   // Data width only sizes the datapath outside this block
   if (DATA_WIDTH == 0) begin : g_bad_data_width
      $error("maxpool_sched: DATA_WIDTH must be non-zero");
   end

   pool_state_e           state_q, state_d;
   logic [DIM_WIDTH-1:0]  width_q, width_d;
   logic [DIM_WIDTH-1:0]  height_q, height_d;
   logic [CH_WIDTH-1:0]   chan_q, chan_d;
   logic [ADDR_WIDTH-1:0] plane_q, plane_d;
   logic [POOL_LAT-1:0]   vld_q, vld_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [DIM_WIDTH-1:0]  out_w_c;
   logic [DIM_WIDTH-1:0]  out_h_c;
   logic                  empty_job_c;
   logic                  issue_c;
   logic                  init_c;
   logic                  gen_last_c;

   // Output map size; odd trailing column/row is dropped
   always_comb begin
      out_w_c     = width_q >> 1;
      out_h_c     = height_q >> 1;
      empty_job_c = (out_w_c == '0) || (out_h_c == '0) || (chan_q == '0);
   end

   // FSM next state, valid pipe and write address
   always_comb begin
      state_d   = state_q;
      width_d   = width_q;
      height_d  = height_q;
      chan_d    = chan_q;
      plane_d   = plane_q;
      vld_d     = vld_q;
      wr_addr_d = wr_addr_q;
      issue_c   = 1'b0;
      init_c    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               width_d  = cfg_width;
               height_d = cfg_height;
               chan_d   = cfg_channels;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            plane_d = ADDR_WIDTH'(height_q) * ADDR_WIDTH'(width_q);
            init_c  = 1'b1;
            state_d = empty_job_c ? ST_FIN : ST_ISSUE;
         end
         ST_ISSUE: begin
            issue_c = out_ready;
            if (issue_c && gen_last_c) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Leave once the pipe will be empty after this cycle
            if ((vld_q[POOL_LAT-2:0] == '0) && (!vld_q[POOL_LAT-1] || out_ready)) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pipe and write address advance only when downstream accepts
      if (out_ready) begin
         vld_d = {vld_q[POOL_LAT-2:0], issue_c};
         if (vld_q[POOL_LAT-1]) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
         end
      end

      if (init_c) begin
         wr_addr_d = '0;
      end

      busy_d = (state_d == ST_LOAD) || (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         width_q   <= '0;
         height_q  <= '0;
         chan_q    <= '0;
         plane_q   <= '0;
         vld_q     <= '0;
         wr_addr_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         width_q   <= width_d;
         height_q  <= height_d;
         chan_q    <= chan_d;
         plane_q   <= plane_d;
         vld_q     <= vld_d;
         wr_addr_q <= wr_addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   pool_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DIM_WIDTH  (DIM_WIDTH),
      .CH_WIDTH   (CH_WIDTH)
   ) u_addr_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .init     (init_c),
      .advance  (issue_c),
      .width    (width_q),
      .out_w    (out_w_c),
      .out_h    (out_h_c),
      .channels (chan_q),
      .plane    (plane_q),
      .addr_a_c (rd_addr_a),
      .addr_b_c (rd_addr_b),
      .addr_c_c (rd_addr_c),
      .addr_d_c (rd_addr_d),
      .last_c   (gen_last_c)
   );

   // Strobes are qualified by out_ready so a stall silences every enable
   always_comb begin
      rd_en   = issue_c;
      pool_v0 = vld_q[0] & out_ready;
      pool_v1 = vld_q[1] & out_ready;
      wr_en   = vld_q[POOL_LAT-1] & out_ready;
      wr_addr = wr_addr_q;
      busy    = busy_q;
      done    = done_q;
   end

endmodule

// File: tb/tb_maxpool_sched.sv
// Self-checking bench for maxpool_sched: models the input RAM and the pool
// unit around the DUT and compares read addresses, write addresses, pooled
// data, latency and job control against a reference built from the map
// geometry with plain loops.
module tb_maxpool_sched;

   localparam int unsigned AW = 20;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 10;
   localparam int unsigned XW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] cfg_width;
   logic [DW-1:0] cfg_height;
   logic [CW-1:0] cfg_channels;
   logic          busy;
   logic          done;
   logic          out_ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
   logic          pool_v0, pool_v1, wr_en;
   logic [AW-1:0] wr_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   maxpool_sched #(
      .DATA_WIDTH (XW),
      .ADDR_WIDTH (AW),
      .DIM_WIDTH  (DW),
      .CH_WIDTH   (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .cfg_channels (cfg_channels),
      .busy         (busy),
      .done         (done),
      .out_ready    (out_ready),
      .rd_en        (rd_en),
      .rd_addr_a    (rd_addr_a),
      .rd_addr_b    (rd_addr_b),
      .rd_addr_c    (rd_addr_c),
      .rd_addr_d    (rd_addr_d),
      .pool_v0      (pool_v0),
      .pool_v1      (pool_v1),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr)
   );

   // Environment: input RAM with 1-cycle latency and the two-stage pool unit
   logic [XW-1:0] mem [0:1023];
   logic [XW-1:0] rd_a, rd_b, rd_c, rd_d, s1_ab, s1_cd, s2;

   function automatic logic [XW-1:0] max2(input logic [XW-1:0] x, input logic [XW-1:0] y);
      return (x > y) ? x : y;
   endfunction

   always @(posedge clk) begin
      if (rd_en) begin
         rd_a <= mem[rd_addr_a[9:0]];
         rd_b <= mem[rd_addr_b[9:0]];
         rd_c <= mem[rd_addr_c[9:0]];
         rd_d <= mem[rd_addr_d[9:0]];
      end
      if (pool_v0) begin
         s1_ab <= max2(rd_a, rd_b);
         s1_cd <= max2(rd_c, rd_d);
      end
      if (pool_v1) begin
         s2 <= max2(s1_ab, s1_cd);
      end
   end

   // Reference: expected windows and pooled results in channel-major order
   typedef struct {
      logic [AW-1:0] a;
      logic [AW-1:0] b;
      logic [AW-1:0] c;
      logic [AW-1:0] d;
   } win_t;

   win_t          exp_rd[$];
   logic [XW-1:0] exp_wr[$];

   task automatic fill_mem(input bit ramp);
      for (int i = 0; i < 1024; i++) begin
         mem[i] = ramp ? XW'(i) : XW'($urandom);
      end
   endtask

   task automatic build_ref(input int w, input int h, input int c);
      win_t          wv;
      logic [AW-1:0] base;
      exp_rd.delete();
      exp_wr.delete();
      for (int ch = 0; ch < c; ch++) begin
         for (int orow = 0; orow < h / 2; orow++) begin
            for (int ocol = 0; ocol < w / 2; ocol++) begin
               base = AW'(ch * h * w + 2 * orow * w + 2 * ocol);
               wv.a = base;
               wv.b = base + AW'(1);
               wv.c = base + AW'(w);
               wv.d = base + AW'(w) + AW'(1);
               exp_rd.push_back(wv);
               exp_wr.push_back(max2(max2(mem[wv.a[9:0]], mem[wv.b[9:0]]),
                                     max2(mem[wv.c[9:0]], mem[wv.d[9:0]])));
            end
         end
      end
   endtask

   // mode 0: out_ready always high; 1: random out_ready; 2: low for cycles 4..6
   // restart_at >= 0 pulses start again at that cycle of the job
   task automatic run_job(input string name, input int w, input int h, input int c,
                          input int mode, input int restart_at, output int busy_cyc);
      int   cyc, post, n_rd, n_wr, n_done, last_wr_cyc, done_cyc, iss, exp_n;
      bit   seen_done;
      int   issue_cyc[$];
      win_t wv;
      logic [XW-1:0] ed;

      build_ref(w, h, c);
      exp_n       = c * (h / 2) * (w / 2);
      cyc         = 0;
      post        = 0;
      n_rd        = 0;
      n_wr        = 0;
      n_done      = 0;
      busy_cyc    = 0;
      last_wr_cyc = -1;
      done_cyc    = -1;
      seen_done   = 1'b0;

      @(negedge clk);
      cfg_width    = DW'(w);
      cfg_height   = DW'(h);
      cfg_channels = CW'(c);
      out_ready    = 1'b1;
      start        = 1'b1;

      while (post < 3 && cyc < 3000) begin
         @(negedge clk);
         start = 1'b0;
         if (restart_at >= 0 && cyc == restart_at) begin
            start        = 1'b1;
            cfg_width    = DW'(6);
            cfg_height   = DW'(6);
            cfg_channels = CW'(2);
         end
         case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = !(cyc >= 4 && cyc < 7);
            default: out_ready = 1'b1;
         endcase
         #1;

         if (!out_ready) begin
            n_checks++;
            if ({rd_en, pool_v0, pool_v1, wr_en} !== 4'b0000) begin
               n_fail++;
               $display("FAIL %s stall_enables cyc=%0d got rd/v0/v1/wr=%b%b%b%b expected 0000",
                        name, cyc, rd_en, pool_v0, pool_v1, wr_en);
            end
         end

         if (rd_en === 1'b1) begin
            n_rd++;
            issue_cyc.push_back(cyc);
            n_checks++;
            if (exp_rd.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_read cyc=%0d got A=%0d expected no read", name, cyc, rd_addr_a);
            end else begin
               wv = exp_rd.pop_front();
               if (rd_addr_a !== wv.a || rd_addr_b !== wv.b || rd_addr_c !== wv.c || rd_addr_d !== wv.d) begin
                  n_fail++;
                  $display("FAIL %s rd_addr cyc=%0d got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d",
                           name, cyc, rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d, wv.a, wv.b, wv.c, wv.d);
               end
            end
         end

         if (wr_en === 1'b1) begin
            n_checks++;
            if (wr_addr !== AW'(n_wr)) begin
               n_fail++;
               $display("FAIL %s wr_addr cyc=%0d got %0d expected %0d", name, cyc, wr_addr, n_wr);
            end
            n_checks++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_write cyc=%0d got data=%0h expected no write", name, cyc, s2);
            end else begin
               ed = exp_wr.pop_front();
               if (s2 !== ed) begin
                  n_fail++;
                  $display("FAIL %s wr_data cyc=%0d got %0h expected %0h", name, cyc, s2, ed);
               end
            end
            if (mode == 0 && issue_cyc.size() > 0) begin
               iss = issue_cyc.pop_front();
               n_checks++;
               if (cyc != iss + 3) begin
                  n_fail++;
                  $display("FAIL %s latency got %0d cycles expected 3", name, cyc - iss);
               end
            end
            n_wr++;
            last_wr_cyc = cyc;
         end

         if (busy === 1'b1) busy_cyc++;
         if (done === 1'b1) begin
            n_done++;
            if (!seen_done) done_cyc = cyc;
            seen_done = 1'b1;
         end
         if (seen_done) post++;
         cyc++;
      end

      n_checks++;
      if (!seen_done) begin
         n_fail++;
         $display("FAIL %s done_timeout got no done in %0d cycles expected done", name, cyc);
      end
      n_checks++;
      if (n_done != 1) begin
         n_fail++;
         $display("FAIL %s done_count got %0d expected 1", name, n_done);
      end
      n_checks++;
      if (n_wr != exp_n) begin
         n_fail++;
         $display("FAIL %s write_count got %0d expected %0d", name, n_wr, exp_n);
      end
      n_checks++;
      if (n_rd != exp_n) begin
         n_fail++;
         $display("FAIL %s read_count got %0d expected %0d", name, n_rd, exp_n);
      end
      if (n_wr > 0) begin
         n_checks++;
         if (done_cyc != last_wr_cyc + 1) begin
            n_fail++;
            $display("FAIL %s done_timing got cyc %0d expected %0d", name, done_cyc, last_wr_cyc + 1);
         end
      end
      n_checks++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL %s idle_after_job got busy/done=%b%b expected 00", name, busy, done);
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      start        = 1'b0;
      out_ready    = 1'b1;
      cfg_width    = '0;
      cfg_height   = '0;
      cfg_channels = '0;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({busy, done, rd_en, pool_v0, pool_v1, wr_en, wr_addr,
           rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b done=%b rd=%b wr=%b wr_addr=%0d B=%0d expected all 0",
                  busy, done, rd_en, wr_en, wr_addr, rd_addr_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_4x4();
      int bc;
      fill_mem(1'b1);
      run_job("basic_4x4x1", 4, 4, 1, 0, -1, bc);
   endtask

   task automatic test_odd_5x3x2();
      int bc;
      fill_mem(1'b0);
      run_job("odd_5x3x2", 5, 3, 2, 0, -1, bc);
   endtask

   task automatic test_stall();
      int bc;
      fill_mem(1'b1);
      run_job("stall_4x4x1", 4, 4, 1, 2, -1, bc);
   endtask

   task automatic test_restart_ignored();
      int bc;
      fill_mem(1'b1);
      run_job("restart_ignored", 4, 4, 1, 0, 2, bc);
   endtask

   task automatic test_degenerate();
      int bc;
      fill_mem(1'b0);
      run_job("width_1", 1, 4, 3, 0, -1, bc);
      n_checks++;
      if (bc < 1 || bc > 2) begin
         n_fail++;
         $display("FAIL width_1 busy_cycles got %0d expected 1..2", bc);
      end
      run_job("chan_0", 4, 4, 0, 0, -1, bc);
      n_checks++;
      if (bc < 1 || bc > 2) begin
         n_fail++;
         $display("FAIL chan_0 busy_cycles got %0d expected 1..2", bc);
      end
   endtask

   task automatic test_reset_mid();
      int  bc;
      int  guard;
      fill_mem(1'b1);
      @(negedge clk);
      cfg_width    = DW'(4);
      cfg_height   = DW'(4);
      cfg_channels = CW'(2);
      out_ready    = 1'b1;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (rd_en !== 1'b1 && guard < 20) begin
         @(negedge clk);
         #1;
         guard++;
      end
      n_checks++;
      if (rd_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_reach_issue got rd_en=%b expected 1", rd_en);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, rd_en, pool_v0, pool_v1, wr_en, wr_addr,
           rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs got busy=%b rd=%b v0=%b v1=%b wr=%b A=%0d expected all 0",
                  busy, rd_en, pool_v0, pool_v1, wr_en, rd_addr_a);
      end
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_no_done got done=%b expected 0", done);
      end
      rst_n = 1'b1;
      fill_mem(1'b0);
      run_job("after_reset_4x4x2", 4, 4, 2, 0, -1, bc);
   endtask

   task automatic test_random();
      int bc;
      for (int k = 0; k < 4; k++) begin
         fill_mem(1'b0);
         run_job("random", int'($urandom_range(2, 9)), int'($urandom_range(2, 9)),
                 int'($urandom_range(1, 3)), 1, -1, bc);
      end
   endtask

   initial begin
      test_reset();
      test_basic_4x4();
      test_odd_5x3x2();
      test_stall();
      test_restart_ignored();
      test_degenerate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
